// File: rtl/encrypt_key_schedule.sv
// -----------------------------------------------------------------------------
// encrypt_key_schedule
// Sequential AES-128 key expansion. Latches a 128-bit cipher key on an
// accepted start and presents round keys 0..10, advancing one key per
// keyValid/keyReady transfer. The completed round-10 key is held in
// finalKey for the final encrypt round.
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   start      begin an expansion (sampled only when idle)
//   cipherKey  128-bit key, FIPS-197 byte order (byte 0 = [127:120])
//   keyReady   downstream accepts roundKey this cycle
//   keyValid   roundKey/roundIdx valid
//   roundKey   current round key
//   roundIdx   index of roundKey, 0..NUM_ROUNDS
//   busy       high while emitting round keys
//   done       one-cycle pulse after the last round key is accepted
//   finalKey   last completed round-10 key
// -----------------------------------------------------------------------------
module encrypt_key_schedule #(
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_W      = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [127:0]       cipherKey,
    input  logic               keyReady,
    output logic               keyValid,
    output logic [127:0]       roundKey,
    output logic [IDX_W-1:0]   roundIdx,
    output logic               busy,
    output logic               done,
    output logic [127:0]       finalKey
);

    // state  | meaning
    // IDLE   | waiting for start, outputs quiet
    // EMIT   | presenting roundKey, advancing on each transfer
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t             state_q;
    logic [127:0]       key_q;
    logic [IDX_W-1:0]   idx_q;
    logic [7:0]         rcon_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;
    logic [127:0]       final_q;

    logic [127:0]       key_d;
    logic [7:0]         rcon_d;
    logic [31:0]        w0, w1, w2, w3;
    logic [31:0]        rot_w, sub_w, t_w;
    logic [31:0]        n0, n1, n2, n3;

    // Next round key is derived straight from the registered key, so the
    // successor is ready the same cycle the current key is presented.
    assign w0    = key_q[127:96];
    assign w1    = key_q[95:64];
    assign w2    = key_q[63:32];
    assign w3    = key_q[31:0];
    assign rot_w = {w3[23:0], w3[31:24]};
    assign sub_w = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]],
                    SBOX[rot_w[15:8]],  SBOX[rot_w[7:0]]};
    assign t_w   = sub_w ^ {rcon_q, 24'h000000};
    assign n0    = w0 ^ t_w;
    assign n1    = w1 ^ n0;
    assign n2    = w2 ^ n1;
    assign n3    = w3 ^ n2;
    assign key_d = {n0, n1, n2, n3};

    // xtime in GF(2^8): 80 wraps to 1B, giving 01..80,1B,36.
    assign rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            rcon_q  <= 8'h01;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            final_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        key_q   <= cipherKey;
                        idx_q   <= '0;
                        rcon_q  <= 8'h01;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (keyReady) begin
                        if (idx_q == LAST_IDX) begin
                            final_q <= key_q;
                            done_q  <= 1'b1;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            key_q  <= key_d;
                            idx_q  <= idx_q + IDX_W'(1);
                            rcon_q <= rcon_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign keyValid = valid_q;
    assign roundKey = key_q;
    assign roundIdx = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign finalKey = final_q;

endmodule

// File: tb/tb_encrypt_key_schedule.sv
module tb_encrypt_key_schedule;

    logic         CLK;
    logic         RST;
    logic         start;
    logic [127:0] cipherKey;
    logic         keyReady;
    logic         keyValid;
    logic [127:0] roundKey;
    logic [3:0]   roundIdx;
    logic         busy;
    logic         done;
    logic [127:0] finalKey;

    encrypt_key_schedule #(.NUM_ROUNDS(10), .IDX_W(4)) dut (
        .CLK(CLK), .RST(RST), .start(start), .cipherKey(cipherKey),
        .keyReady(keyReady), .keyValid(keyValid), .roundKey(roundKey),
        .roundIdx(roundIdx), .busy(busy), .done(done), .finalKey(finalKey)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sb [256];
    logic [127:0] exp_keys [11];
    logic [127:0] got [11];
    logic [127:0] exp_final = '0;

    // Reference arithmetic: S-box derived from GF(2^8) inverse + affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? (8'(x << 1) ^ 8'h1B) : 8'(x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic compute_expected(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 11; k++)
            exp_keys[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One complete expansion. Optional stall of stall_n cycles at stall_at,
    // and a start pulse with a foreign key at poke_at (must be ignored).
    task automatic run_exp(input logic [127:0] key, input int stall_at,
                           input int stall_n, input int poke_at);
        compute_expected(key);
        start = 1'b1; cipherKey = key;
        tick();
        start = 1'b0; cipherKey = rand_key();
        for (int k = 0; k < 11; k++) begin
            chk("valid", keyValid, 1);
            chk("busy", busy, 1);
            chk("idx", roundIdx, k);
            chk("key", roundKey, exp_keys[k]);
            chk("done_low", done, 0);
            chk("final_hold", finalKey, exp_final);
            got[k] = roundKey;
            if (k == stall_at) begin
                keyReady = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    chk("stall_idx", roundIdx, k);
                    chk("stall_key", roundKey, exp_keys[k]);
                    chk("stall_valid", keyValid, 1);
                    chk("stall_done", done, 0);
                end
                keyReady = 1'b1;
            end
            if (k == poke_at) begin
                start = 1'b1; cipherKey = rand_key();
            end
            tick();
            start = 1'b0;
        end
        chk("done_pulse", done, 1);
        chk("valid_end", keyValid, 0);
        chk("busy_end", busy, 0);
        exp_final = exp_keys[10];
        chk("final_key", finalKey, exp_final);
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; keyReady = 1'b1; cipherKey = '0;
        build_sbox();
        tick(); tick();
        chk("rst_valid", keyValid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", roundIdx, 0);
        chk("rst_key", roundKey, 0);
        chk("rst_final", finalKey, 0);
        RST = 1'b0;

        // Idle quiet
        for (int i = 0; i < 20; i++) begin
            cipherKey = rand_key();
            tick();
            chk("idle_valid", keyValid, 0);
            chk("idle_done", done, 0);
            chk("idle_final", finalKey, 0);
        end

        // FIPS-197 vector, no backpressure
        run_exp(128'h2b7e151628aed2a6abf7158809cf4f3c, -1, 0, -1);
        chk("fips_idx0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("fips_idx1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_idx10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("fips_final", finalKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        tick();
        chk("done_one_cycle", done, 0);
        chk("final_after", finalKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Backpressure at idx4 for 3 cycles
        run_exp(128'h2b7e151628aed2a6abf7158809cf4f3c, 4, 3, -1);
        chk("bp_idx5", got[5], exp_keys[5]);
        tick();

        // Rcon wrap key, with an ignored start at idx5
        run_exp(128'h000102030405060708090a0b0c0d0e0f, -1, 0, 5);
        chk("rcon_idx9", got[9], 128'h549932d1f08557681093ed9cbe2c974e);
        chk("rcon_idx10", got[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Start in the done cycle: next expansion begins immediately
        run_exp(rand_key(), -1, 0, -1);
        tick();

        // Random keys with random stalls and ignored starts
        for (int r = 0; r < 4; r++) begin
            run_exp(rand_key(), int'($urandom_range(0, 10)),
                    int'($urandom_range(1, 4)), int'($urandom_range(0, 10)));
            tick();
        end

        // Reset mid-expansion at idx6
        compute_expected(128'h000102030405060708090a0b0c0d0e0f);
        start = 1'b1; cipherKey = 128'h000102030405060708090a0b0c0d0e0f;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("pre_rst_idx", roundIdx, 6);
        chk("pre_rst_key", roundKey, exp_keys[6]);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_final = '0;
        chk("mrst_valid", keyValid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_idx", roundIdx, 0);
        chk("mrst_final", finalKey, 0);
        chk("mrst_done", done, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("mrst_no_done", done, 0);
            chk("mrst_quiet", keyValid, 0);
        end

        // Expansion after reset starts cleanly (Rcon restored)
        run_exp(rand_key(), 2, 1, -1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
